// File: rtl/que_pkg.sv
// Edge-mode encodings, edge detector and hit-counter width shared by the edge queue.
package que_pkg;

  localparam logic [1:0] EDGE_RISE = 2'b00;
  localparam logic [1:0] EDGE_FALL = 2'b01;
  localparam logic [1:0] EDGE_BOTH = 2'b10;

  localparam int unsigned HIT_CNT_W = 8;

  // Edge between consecutive taps a (earlier) and b (later); mode 11 behaves as rising.
  function automatic logic edge_fn(input logic [1:0] mode, input logic a, input logic b);
    logic e;
    case (mode)
      EDGE_FALL: e = a & ~b;
      EDGE_BOTH: e = a ^ b;
      default:   e = ~a & b;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/edge_que_ch.sv
// One channel of the edge queue: tap capture, edge flags, windowed replay, optional popcount.
// Popcount output exists only when QUE_HIT_COUNT_EN is defined.
module edge_que_ch
  import que_pkg::*;
#(
  parameter int unsigned DEPTH = 101,
  parameter int unsigned WIN   = 3,
  parameter int unsigned SKIP  = 2,
  parameter int unsigned CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             syn,
  input  logic             cap_en,
  input  logic [CNT_W-1:0] cap_idx,
  input  logic             in,
  input  logic [1:0]       edge_mode,
  output logic             out,
  output logic             flag_nz_c
`ifdef QUE_HIT_COUNT_EN
  ,
  output logic [HIT_CNT_W-1:0] hit_cnt
`endif
);

  logic [DEPTH-1:0] q_q, q_d;
  logic [DEPTH-1:0] flag_q, flag_d;
  logic             out_q, out_d;

  // syn turns the captured taps into flags and restarts capture; otherwise flags drain toward 0.
  always_comb begin
    q_d    = q_q;
    flag_d = flag_q;
    if (syn) begin
      q_d    = '0;
      flag_d = '0;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        if (i >= SKIP) flag_d[i] = edge_fn(edge_mode, q_q[i-1], q_q[i]);
      end
    end else begin
      flag_d = {1'b0, flag_q[DEPTH-1:1]};
      if (cap_en) q_d[cap_idx] = in;
    end
    out_d     = |flag_d[WIN-1:0];
    flag_nz_c = |flag_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q    <= '0;
      flag_q <= '0;
      out_q  <= 1'b0;
    end else begin
      q_q    <= q_d;
      flag_q <= flag_d;
      out_q  <= out_d;
    end
  end

  assign out = out_q;

`ifdef QUE_HIT_COUNT_EN
  logic [HIT_CNT_W-1:0] hit_q, hit_d;
  logic [31:0]          pop;

  // Saturating count of the flags loaded at frame close; held until the next syn.
  always_comb begin
    pop   = '0;
    hit_d = hit_q;
    for (int unsigned i = 0; i < DEPTH; i++) pop = pop + 32'(flag_d[i]);
    if (syn) hit_d = (pop > 32'd255) ? '1 : HIT_CNT_W'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hit_q <= '0;
    else        hit_q <= hit_d;
  end

  assign hit_cnt = hit_q;
`endif

endmodule

// File: rtl/edge_que_n.sv
// Multi-channel frame capture/replay edge queue for the coincidence path.
// Define QUE_HIT_COUNT_EN to add the per-channel hit_cnt output.
module edge_que_n
  import que_pkg::*;
#(
  parameter int unsigned CH    = 2,
  parameter int unsigned DEPTH = 101,
  parameter int unsigned WIN   = 3,
  parameter int unsigned SKIP  = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          syn,
  input  logic [CH-1:0] in,
  input  logic [1:0]    edge_mode,
  output logic [CH-1:0] out,
  output logic          busy
`ifdef QUE_HIT_COUNT_EN
  ,
  output logic [HIT_CNT_W*CH-1:0] hit_cnt
`endif
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cap_en_c;
  logic             busy_q, busy_d;
  logic [CH-1:0]    flag_nz_c;

  // Tap counter: 0 = idle until first syn, DEPTH = frame full (taps hold).
  always_comb begin
    cap_en_c = ~syn && (cnt_q != '0) && (cnt_q < CNT_W'(DEPTH));
    cnt_d    = cnt_q;
    if (syn)           cnt_d = CNT_W'(1);
    else if (cap_en_c) cnt_d = cnt_q + CNT_W'(1);
    busy_d = |flag_nz_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;

  for (genvar c = 0; c < CH; c++) begin : g_ch
    edge_que_ch #(
      .DEPTH (DEPTH),
      .WIN   (WIN),
      .SKIP  (SKIP),
      .CNT_W (CNT_W)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .syn       (syn),
      .cap_en    (cap_en_c),
      .cap_idx   (cnt_q),
      .in        (in[c]),
      .edge_mode (edge_mode),
      .out       (out[c]),
      .flag_nz_c (flag_nz_c[c])
`ifdef QUE_HIT_COUNT_EN
      ,
      .hit_cnt   (hit_cnt[HIT_CNT_W*c +: HIT_CNT_W])
`endif
    );
  end

endmodule

// File: tb/tb_edge_que_n.sv
// Bench for edge_que_n: directed vector table, corner sequences and random traffic vs a frame model.
module tb_edge_que_n;

  localparam int CH    = 2;
  localparam int DEPTH = 101;
  localparam int WIN   = 3;
  localparam int SKIP  = 2;

  logic          clk;
  logic          rst_n;
  logic          syn;
  logic [CH-1:0] in_v;
  logic [1:0]    edge_mode;
  logic [CH-1:0] out_v;
  logic          busy;
`ifdef QUE_HIT_COUNT_EN
  logic [8*CH-1:0] hit_cnt;
`endif

  int checks = 0;
  int errors = 0;

  edge_que_n #(.CH(CH), .DEPTH(DEPTH), .WIN(WIN), .SKIP(SKIP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .syn       (syn),
    .in        (in_v),
    .edge_mode (edge_mode),
    .out       (out_v),
    .busy      (busy)
`ifdef QUE_HIT_COUNT_EN
    ,
    .hit_cnt   (hit_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog t=%0t act=running exp=finished", $time);
    $fatal(1, "watchdog");
  end

  // Frame model: captured samples, edge tap list per frame, cycles since frame close.
  bit mq  [CH][DEPTH];
  bit mev [CH][DEPTH];
  int mk;
  int mj;
  int mhit[CH];

  function automatic bit edge_rule(input logic [1:0] m, input bit a, input bit b);
    if (m == 2'b01) return a && !b;
    if (m == 2'b10) return a != b;
    return !a && b;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      for (int i = 0; i < DEPTH; i++) begin
        mq[c][i]  = 0;
        mev[c][i] = 0;
      end
      mhit[c] = 0;
    end
    mk = 0;
    mj = 0;
  endtask

  task automatic model_edge(input logic s, input logic [CH-1:0] d, input logic [1:0] m);
    int n;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (s) begin
      for (int c = 0; c < CH; c++) begin
        n = 0;
        for (int i = 0; i < DEPTH; i++) begin
          mev[c][i] = 0;
          if (i >= SKIP && i >= 1) mev[c][i] = edge_rule(m, mq[c][i-1], mq[c][i]);
          if (mev[c][i]) n++;
        end
        mhit[c] = (n > 255) ? 255 : n;
        for (int i = 0; i < DEPTH; i++) mq[c][i] = 0;
      end
      mk = 1;
      mj = 0;
    end else begin
      if (mk >= 1 && mk < DEPTH) begin
        for (int c = 0; c < CH; c++) mq[c][mk] = d[c];
        mk++;
      end
      mj++;
    end
  endtask

  function automatic logic [CH-1:0] model_out();
    logic [CH-1:0] r = '0;
    for (int c = 0; c < CH; c++)
      for (int i = 0; i < DEPTH; i++)
        if (mev[c][i] && mj <= i && mj + WIN - 1 >= i) r[c] = 1'b1;
    return r;
  endfunction

  function automatic logic model_busy();
    for (int c = 0; c < CH; c++)
      for (int i = 0; i < DEPTH; i++)
        if (mev[c][i] && mj <= i) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t act=%0h exp=%0h", name, $time, act, exp);
    end
  endtask

  task automatic check_model();
    chk("model_out", 32'(out_v), 32'(model_out()));
    chk("model_busy", 32'(busy), 32'(model_busy()));
`ifdef QUE_HIT_COUNT_EN
    for (int c = 0; c < CH; c++) chk("model_hit", 32'(hit_cnt[8*c +: 8]), 32'(mhit[c]));
`endif
  endtask

  task automatic step(input logic s, input logic [CH-1:0] d, input logic [1:0] m);
    @(negedge clk);
    syn       = s;
    in_v      = d;
    edge_mode = m;
    @(posedge clk);
    model_edge(s, d, m);
    #1;
    check_model();
  endtask

  task automatic check_idle(input string name);
    chk({name, "_out"}, 32'(out_v), 32'd0);
    chk({name, "_busy"}, 32'(busy), 32'd0);
`ifdef QUE_HIT_COUNT_EN
    chk({name, "_hit"}, 32'(hit_cnt), 32'd0);
`endif
  endtask

  typedef struct {
    logic [1:0] mode;
    int ch;
    int lo;
    int hi;
    int w0s;
    int w0e;
    int w1s;
    int w1e;
    int busy_end;
    int hits;
  } vec_t;

  function automatic bit in_win(input int j, input int s, input int e);
    return s >= 0 && j >= s && j <= e;
  endfunction

  vec_t tbl[6];

  initial begin
    logic [CH-1:0] d;
    logic [1:0]    m;
    logic          s;
    int            burst;

    tbl[0] = '{2'b00, 0, 40, 100, 38, 40, -1, -1, 40, 1};
    tbl[1] = '{2'b10, 1, 10, 19, 8, 10, 18, 20, 20, 2};
    tbl[2] = '{2'b00, 0, 1, 100, -1, -1, -1, -1, -1, 0};
    tbl[3] = '{2'b00, 0, 2, 100, 0, 2, -1, -1, 2, 1};
    tbl[4] = '{2'b01, 1, 1, 49, 48, 50, -1, -1, 50, 1};
    tbl[5] = '{2'b11, 0, 70, 100, 68, 70, -1, -1, 70, 1};

    rst_n = 1'b0;
    syn = 1'b0;
    in_v = '0;
    edge_mode = 2'b00;
    model_reset();
    #12;
    check_idle("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // No capture before the first syn: toggling input leaves the first replay empty.
    for (int k = 0; k < 20; k++) step(1'b0, CH'(k & 3), 2'b10);
    step(1'b1, '0, 2'b10);
    check_idle("pre_syn");

    for (int v = 0; v < 6; v++) begin
      step(1'b1, '0, tbl[v].mode);
      for (int k = 1; k < DEPTH; k++) begin
        d = '0;
        d[tbl[v].ch] = (k >= tbl[v].lo && k <= tbl[v].hi);
        step(1'b0, d, tbl[v].mode);
      end
      for (int j = 0; j < DEPTH; j++) begin
        step(j == 0, '0, tbl[v].mode);
        chk($sformatf("tbl%0d_out_j%0d", v, j), 32'(out_v[tbl[v].ch]),
            32'(in_win(j, tbl[v].w0s, tbl[v].w0e) || in_win(j, tbl[v].w1s, tbl[v].w1e)));
        chk($sformatf("tbl%0d_other_j%0d", v, j), 32'(out_v[1 - tbl[v].ch]), 32'd0);
        chk($sformatf("tbl%0d_busy_j%0d", v, j), 32'(busy), 32'(j <= tbl[v].busy_end));
`ifdef QUE_HIT_COUNT_EN
        if (j == 0) chk($sformatf("tbl%0d_hit", v), 32'(hit_cnt[8*tbl[v].ch +: 8]), 32'(tbl[v].hits));
`endif
      end
    end

    // Short frame: syn after 30 cycles truncates a capture whose rise would come at tap 50.
    step(1'b1, '0, 2'b00);
    for (int k = 1; k < 30; k++) step(1'b0, {1'b0, k >= 50}, 2'b00);
    step(1'b1, '0, 2'b00);
    for (int j = 1; j < 60; j++) begin
      step(1'b0, '0, 2'b00);
      chk("short_busy", 32'(busy), 32'd0);
    end

    // Reset during replay of an edge at tap 40.
    step(1'b1, '0, 2'b00);
    for (int k = 1; k < DEPTH; k++) step(1'b0, {1'b0, k >= 40}, 2'b00);
    step(1'b1, '0, 2'b00);
    for (int j = 1; j <= 20; j++) step(1'b0, '0, 2'b00);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_idle("async_rst");
    for (int k = 0; k < 3; k++) step(1'b0, 2'b11, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, '0, 2'b00);
    check_idle("post_rst_syn");

    // syn held high, then one real frame with a rise at tap 60.
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 2'b11, 2'b10);
      chk("syn_held_busy", 32'(busy), 32'd0);
    end
    for (int k = 1; k < DEPTH; k++) step(1'b0, {1'b0, k >= 60}, 2'b00);
    for (int j = 0; j < 70; j++) begin
      step(j == 0, '0, 2'b00);
      chk($sformatf("held_out_j%0d", j), 32'(out_v), 32'(j >= 58 && j <= 60));
    end

    // Random frames, modes and inputs against the model.
    d = '0;
    burst = 0;
    for (int n = 0; n < 3000; n++) begin
      if (burst > 0) begin
        s = 1'b1;
        burst--;
      end else begin
        s = ($urandom_range(0, 59) == 0);
        if ($urandom_range(0, 9) == 0 && s) burst = $urandom_range(1, 3);
      end
      for (int c = 0; c < CH; c++) if ($urandom_range(0, 7) == 0) d[c] = ~d[c];
      m = 2'($urandom_range(0, 3));
      step(s, d, m);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
